microsequencer: RTL and testbench



---
 rtl/microsequencer.sv | 87 ++++++++
 tb/tb_microsequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/microsequencer.sv
// Microcode sequencer: keeps the T-state counter, drives the fixed two-step
// fetch, addresses the microcode ROM with {opcode, tstate} for execute steps,
// flags the final microstep of each instruction and counts retired ones.
module microsequencer #(
  parameter int OPCODE_BITS = 8,
  parameter int TSTATE_BITS = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [OPCODE_BITS-1:0]             opcode,
  input  logic                               stall,
  output logic [OPCODE_BITS+TSTATE_BITS-1:0] rom_addr,
  input  logic [15:0]                        rom_data,
  output logic [15:0]                        uinstr,
  output logic [TSTATE_BITS-1:0]             tstate,
  output logic                               instr_done,
  output logic [15:0]                        instr_count
);

  localparam logic [TSTATE_BITS-1:0] T_FETCH0 = TSTATE_BITS'(0);
  localparam logic [TSTATE_BITS-1:0] T_FETCH1 = TSTATE_BITS'(1);
  localparam logic [TSTATE_BITS-1:0] T_EXEC0  = TSTATE_BITS'(2);
  localparam logic [TSTATE_BITS-1:0] T_LAST   = '1;

  // Fixed fetch microinstructions and the bus-idle word.
  localparam logic [15:0] UI_FETCH0 = 16'h0040;  // PC out, MAR in
  localparam logic [15:0] UI_FETCH1 = 16'h3480;  // RAM out, IR in, P+
  localparam logic [15:0] UI_IDLE   = 16'h0000;

  logic                   in_exec;
  logic                   early_end;
  logic [TSTATE_BITS-1:0] tstate_nxt;
  logic [15:0]            count_nxt;

  // ROM is always addressed, even during fetch where its word is ignored.
  assign rom_addr = {opcode, tstate};

  // End-of-instruction detection: a zero ROM word in an execute step, or the
  // last T-state. Stall overrides both so the step can re-execute later.
  always_comb begin
    in_exec    = (tstate >= T_EXEC0);
    early_end  = in_exec && (rom_data == UI_IDLE);
    instr_done = !stall && (early_end || (tstate == T_LAST));
  end

  // Microinstruction mux: fixed fetch words, ROM word in execute, idle on stall.
  always_comb begin
    // NOTE: default assignment first so every path drives uinstr (no latch).
    uinstr = rom_data;
    if (stall) begin
      uinstr = UI_IDLE;
    end else begin
      unique case (tstate)
        T_FETCH0: uinstr = UI_FETCH0;
        T_FETCH1: uinstr = UI_FETCH1;
        default:  uinstr = rom_data;
      endcase
    end
  end

  // Next-state: hold on stall, restart and count on done, else advance.
  always_comb begin
    tstate_nxt = tstate;
    count_nxt  = instr_count;
    if (!stall) begin
      if (instr_done) begin
        tstate_nxt = T_FETCH0;
        count_nxt  = instr_count + 16'd1;  // wraps 0xFFFF -> 0x0000
      end else begin
        tstate_nxt = tstate + TSTATE_BITS'(1);
      end
    end
  end

  // State register: T-state and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tstate      <= T_FETCH0;
      instr_count <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments for all registered state.
      tstate      <= tstate_nxt;
      instr_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Directed self-checking bench for microsequencer with a behavioural ROM.
module tb_microsequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  opcode;
  logic        stall;
  logic [10:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] uinstr;
  logic [2:0]  tstate;
  logic        instr_done;
  logic [15:0] instr_count;

  logic [15:0] rom [0:2047];
  int n_cmp = 0;
  int n_err = 0;

  microsequencer #(.OPCODE_BITS(8), .TSTATE_BITS(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .stall       (stall),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .uinstr      (uinstr),
    .tstate      (tstate),
    .instr_done  (instr_done),
    .instr_count (instr_count)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check all outputs 1ns after the caller's negedge input update, then
  // advance to the next negedge.
  task automatic step(input string tag, input logic [15:0] eu, input logic [2:0] et,
                      input logic ed, input logic [15:0] ec);
    #1;
    check({tag, " uinstr"}, 32'(uinstr), 32'(eu));
    check({tag, " tstate"}, 32'(tstate), 32'(et));
    check({tag, " done"},   32'(instr_done), 32'(ed));
    check({tag, " count"},  32'(instr_count), 32'(ec));
    @(negedge clk);
  endtask

  // Minimal instruction on opcode 0x01 (T2 word is the terminator).
  task automatic run_min(input logic [15:0] c);
    opcode = 8'h01;
    step("min T0", 16'h0040, 3'd0, 1'b0, c);
    step("min T1", 16'h3480, 3'd1, 1'b0, c);
    step("min T2", 16'h0000, 3'd2, 1'b1, c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
    rom[{8'h12, 3'd2}] = 16'h4E40;
    rom[{8'h12, 3'd3}] = 16'h0000;
    rom[{8'h12, 3'd4}] = 16'hDEAD;  // must never be reached
    for (int t = 2; t < 8; t++) rom[{8'h34, 3'(t)}] = 16'h0100 + 16'(t);

    // Reset and fetch
    rst_n = 1'b0; stall = 1'b0; opcode = 8'h12;
    #2;
    check("rst tstate", 32'(tstate), 32'd0);
    check("rst count",  32'(instr_count), 32'd0);
    check("rst uinstr", 32'(uinstr), 32'h0040);
    check("rst done",   32'(instr_done), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step("f T0", 16'h0040, 3'd0, 1'b0, 16'd0);
    step("f T1", 16'h3480, 3'd1, 1'b0, 16'd0);
    #1 check("f addr T2", 32'(rom_addr), 32'h092);
    step("f T2", 16'h4E40, 3'd2, 1'b0, 16'd0);
    #1 check("f addr T3", 32'(rom_addr), 32'h093);
    step("f T3", 16'h0000, 3'd3, 1'b1, 16'd0);

    // Full-length instruction
    opcode = 8'h34;
    step("full T0", 16'h0040, 3'd0, 1'b0, 16'd1);
    step("full T1", 16'h3480, 3'd1, 1'b0, 16'd1);
    for (int t = 2; t < 8; t++)
      step("full Tx", 16'h0100 + 16'(t), 3'(t), (t == 7), 16'd1);

    // Stall at T2 for three cycles
    step("stl T0", 16'h0040, 3'd0, 1'b0, 16'd2);
    step("stl T1", 16'h3480, 3'd1, 1'b0, 16'd2);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) step("stl held", 16'h0000, 3'd2, 1'b0, 16'd2);
    stall = 1'b0;
    step("stl T2", 16'h0102, 3'd2, 1'b0, 16'd2);
    for (int t = 3; t < 8; t++)
      step("stl Tx", 16'h0100 + 16'(t), 3'(t), (t == 7), 16'd2);

    // Stall coinciding with the terminator at T3
    opcode = 8'h12;
    step("st T0", 16'h0040, 3'd0, 1'b0, 16'd3);
    step("st T1", 16'h3480, 3'd1, 1'b0, 16'd3);
    step("st T2", 16'h4E40, 3'd2, 1'b0, 16'd3);
    stall = 1'b1;
    step("st held", 16'h0000, 3'd3, 1'b0, 16'd3);
    step("st held", 16'h0000, 3'd3, 1'b0, 16'd3);
    stall = 1'b0;
    step("st rel", 16'h0000, 3'd3, 1'b1, 16'd3);

    // Reach count 7, then reset asynchronously mid-T5
    run_min(16'd4);
    run_min(16'd5);
    run_min(16'd6);
    opcode = 8'h34;
    step("ar T0", 16'h0040, 3'd0, 1'b0, 16'd7);
    step("ar T1", 16'h3480, 3'd1, 1'b0, 16'd7);
    for (int t = 2; t < 5; t++) step("ar Tx", 16'h0100 + 16'(t), 3'(t), 1'b0, 16'd7);
    #1 check("ar pre tstate", 32'(tstate), 32'd5);
    rst_n = 1'b0;
    #1;
    check("ar tstate", 32'(tstate), 32'd0);
    check("ar count",  32'(instr_count), 32'd0);
    check("ar uinstr", 32'(uinstr), 32'h0040);
    check("ar done",   32'(instr_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_min(16'd0);

    // Counter wrap: preload 0xFFFE, retire two instructions
    force dut.instr_count = 16'hFFFE;
    #1 release dut.instr_count;
    run_min(16'hFFFE);
    run_min(16'hFFFF);
    step("wrap T0", 16'h0040, 3'd0, 1'b0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
